instr_mem_pipe: RTL and testbench
=================================

Name: instr_mem_pipe

Overview:
- Parametrised successor to the fixed 16-entry instruction ROM.
- Synchronous-read instruction memory with a valid/ready fetch request channel, a registered response channel, a flush input for branch redirect, and a write port for loading programs at runtime.
- Sits between the fetch stage (PC generator) and decode; replaces the combinational `mem[pc]` lookup so fetch can be pipelined and stalled.

Parameters:
- WIDTH, 32, instruction word width in bits.
- DEPTH_LOG2, 4, log2 of the number of words (default 16 words).
- ADDR_W, 32, width of the PC and write-address inputs.

Ports:
- clk  in  1  clock; all state updates on posedge.
- rst_n  in  1  asynchronous, active-low reset.
- req_valid  in  1  fetch request valid.
- req_ready  out  1  block can accept a request this cycle.
- req_pc  in  ADDR_W  word address to fetch.
- rsp_valid  out  1  response valid.
- rsp_ready  in  1  decode accepts the response.
- rsp_inst  out  WIDTH  fetched instruction.
- rsp_pc  out  ADDR_W  PC that the response belongs to.
- rsp_fault  out  1  fetch fault (out-of-range PC; parity error when enabled).
- flush  in  1  discard the held or in-flight response (branch redirect).
- wr_en  in  1  program-load write strobe.
- wr_addr  in  ADDR_W  write word address.
- wr_data  in  WIDTH  write data.

Behaviour:
- Storage:
  - 2**DEPTH_LOG2 words, no reset; contents are defined only after being written.
  - Writes with wr_addr >= 2**DEPTH_LOG2 are silently dropped.
- Reset (async assert, sync-safe deassert): rsp_valid=0, rsp_inst=0, rsp_pc=0, rsp_fault=0. req_ready is 1 one cycle after deassert.
- Handshakes:
  - Request accepted on a cycle where req_valid && req_ready.
  - Response completes on a cycle where rsp_valid && rsp_ready.
- Single-entry output register; req_ready = !rsp_valid || rsp_ready (combinational; no dependence on req_valid).
- Latency:
  - A request accepted in cycle N produces rsp_valid=1 in cycle N+1.
  - rsp_inst = mem[req_pc], rsp_pc = req_pc.
  - Back-to-back throughput is 1/cycle while rsp_ready=1.
- Stall: while rsp_valid && !rsp_ready, rsp_inst, rsp_pc and rsp_fault hold stable and no new request is accepted.
- Out-of-range PC (req_pc >= 2**DEPTH_LOG2): accepted normally; response has rsp_fault=1, rsp_inst=0. No wrap-around or aliasing.
- Flush:
  - In the cycle flush=1, the held response is dropped: rsp_valid=0 next cycle unless a new request is also accepted.
  - req_ready is forced to 1 while flush=1.
  - A request presented in the same cycle as flush is accepted and becomes the next response; this is the redirect target.
  - A response that completes in the flush cycle is still counted as consumed by decode.
- Write/read collision (same cycle, same in-range address): the read returns the OLD word (read-first). The new word is visible to requests accepted from the next cycle.
- No internal state machine beyond the rsp_valid flag: states are EMPTY (rsp_valid=0) and FULL (rsp_valid=1).
  - EMPTY->FULL on accept.
  - FULL->FULL on accept with completion.
  - FULL->EMPTY on completion without accept, or on flush without accept.
  - Reset during FULL returns to EMPTY immediately.

Optional Feature:
- Macro: INSTR_MEM_PARITY_EN.
- Defined:
  - Each word stores an extra even-parity bit, computed on write.
  - On read the parity is rechecked; a mismatch sets rsp_fault=1 while rsp_inst still carries the stored data.
  - Unwritten words are treated as unknown, so the bench writes before reading.
  - An extra test-only input par_flip (1 bit) inverts the stored parity bit on the current write.
- Undefined: no parity storage, no par_flip port; rsp_fault reflects only the out-of-range condition.

Test Plan:
- Load words 0..6 via the write port with the loop program (MOV, MOV, MPY, ADD, CMP, BR, HALT); fetch PC 0..6 back-to-back with rsp_ready=1 -> rsp_valid every cycle from the cycle after the first accept, rsp_pc 0..6, rsp_inst matches the written words, rsp_fault=0.
- Fetch PC 2, hold rsp_ready=0 for 3 cycles while req_valid=1 with PC 3 -> req_ready=0, rsp_inst/rsp_pc hold the PC-2 word for 3 cycles; PC 3 response appears the cycle after rsp_ready rises.
- Fetch PC 16 with DEPTH_LOG2=4 -> rsp_fault=1, rsp_inst=0. Write to address 20 -> no word changes, verified by reading all 16 words back.
- With a stalled response for PC 4, pulse flush together with a request for PC 2 -> next cycle rsp_pc=2; the PC-4 response is never observed with rsp_ready=1.
- Same cycle: wr_en to address 5 with 0xDEADBEEF and fetch PC 5 -> response is the old word; refetch of PC 5 -> 0xDEADBEEF.
- Assert rst_n=0 mid-stream with rsp_valid=1 -> rsp_valid, rsp_inst, rsp_pc and rsp_fault are 0 before the next clock edge. With INSTR_MEM_PARITY_EN, a write with par_flip=1 then a read -> rsp_fault=1.

Source files
------------

// File: rtl/instr_mem_pipe.sv
// instr_mem_pipe: synchronous-read instruction memory with a valid/ready
// fetch request channel, a single-entry registered response, a flush input
// for branch redirect and a runtime program-load write port.
//
// Parameters:
//   WIDTH      instruction word width
//   DEPTH_LOG2 log2 of word count (2**DEPTH_LOG2 words)
//   ADDR_W     width of PC / write address
//
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   req_valid/req_ready   fetch request handshake, req_pc = word address
//   rsp_valid/rsp_ready   response handshake
//   rsp_inst/rsp_pc       fetched word and the PC it belongs to
//   rsp_fault             out-of-range PC (or parity error when enabled)
//   flush                 drop held response; forces req_ready
//   wr_en/wr_addr/wr_data program-load write port (out-of-range dropped)
//   par_flip              (INSTR_MEM_PARITY_EN only) invert stored parity
//
// Optional feature macro: INSTR_MEM_PARITY_EN adds an even-parity bit per
// word, checked on read, plus the test-only par_flip input.
module instr_mem_pipe #(
  parameter int WIDTH      = 32,
  parameter int DEPTH_LOG2 = 4,
  parameter int ADDR_W     = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [ADDR_W-1:0] req_pc,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [WIDTH-1:0]  rsp_inst,
  output logic [ADDR_W-1:0] rsp_pc,
  output logic              rsp_fault,
  input  logic              flush,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [WIDTH-1:0]  wr_data
`ifdef INSTR_MEM_PARITY_EN
  ,
  input  logic              par_flip
`endif
);

  localparam int unsigned DEPTH = 1 << DEPTH_LOG2;

  typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} state_t;

  state_t                state;
  logic                  live_q;
  logic [WIDTH-1:0]      mem [DEPTH];
  logic [DEPTH_LOG2-1:0] rd_idx;
  logic [DEPTH_LOG2-1:0] wr_idx;
  logic                  rd_in_range;
  logic                  wr_in_range;
  logic [WIDTH-1:0]      rd_word;
  logic                  rd_bad;
  logic                  accept;
  logic                  complete;

  // Range checks look at every address bit above the index so high PCs
  // never alias onto a stored word.
  assign rd_in_range = ((req_pc >> DEPTH_LOG2) == '0);
  assign wr_in_range = ((wr_addr >> DEPTH_LOG2) == '0);
  assign rd_idx      = req_pc[DEPTH_LOG2-1:0];
  assign wr_idx      = wr_addr[DEPTH_LOG2-1:0];
  assign rd_word     = mem[rd_idx];

  assign rsp_valid = (state == FULL);
  // live_q keeps ready low until the first clock after reset release.
  assign req_ready = live_q && (!rsp_valid || rsp_ready || flush);
  assign accept    = req_valid && req_ready;
  assign complete  = rsp_valid && rsp_ready;

`ifdef INSTR_MEM_PARITY_EN
  logic par_mem [DEPTH];

  always_ff @(posedge clk) begin
    if (wr_en && wr_in_range) begin
      par_mem[wr_idx] <= (^wr_data) ^ par_flip;
    end
  end

  assign rd_bad = !rd_in_range || ((^rd_word) != par_mem[rd_idx]);
`else
  assign rd_bad = !rd_in_range;
`endif

  // Storage has no reset; the read above samples the pre-write contents,
  // giving read-first behaviour on a same-address collision.
  always_ff @(posedge clk) begin
    if (wr_en && wr_in_range) begin
      mem[wr_idx] <= wr_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= EMPTY;
      live_q    <= 1'b0;
      rsp_inst  <= '0;
      rsp_pc    <= '0;
      rsp_fault <= 1'b0;
    end else begin
      live_q <= 1'b1;
      if (accept) begin
        state     <= FULL;
        rsp_pc    <= req_pc;
        rsp_inst  <= rd_in_range ? rd_word : '0;
        rsp_fault <= rd_bad;
      end else if (complete || flush) begin
        state <= EMPTY;
      end
    end
  end

endmodule

// File: tb/tb_instr_mem_pipe.sv
// Directed self-checking bench for instr_mem_pipe (default parameters).
module tb_instr_mem_pipe;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid;
  logic        req_ready;
  logic [31:0] req_pc;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_inst;
  logic [31:0] rsp_pc;
  logic        rsp_fault;
  logic        flush;
  logic        wr_en;
  logic [31:0] wr_addr;
  logic [31:0] wr_data;
`ifdef INSTR_MEM_PARITY_EN
  logic        par_flip;
`endif

  int checks = 0;
  int errors = 0;

  logic [31:0] exp_mem [16];

  instr_mem_pipe #(.WIDTH(32), .DEPTH_LOG2(4), .ADDR_W(32)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_pc    (req_pc),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_inst  (rsp_inst),
    .rsp_pc    (rsp_pc),
    .rsp_fault (rsp_fault),
    .flush     (flush),
    .wr_en     (wr_en),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data)
`ifdef INSTR_MEM_PARITY_EN
    ,
    .par_flip  (par_flip)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    exp_mem[0] = 32'h1000_0005;  // MOV
    exp_mem[1] = 32'h1100_0003;  // MOV
    exp_mem[2] = 32'h2201_0000;  // MPY
    exp_mem[3] = 32'h3302_0000;  // ADD
    exp_mem[4] = 32'h4003_0000;  // CMP
    exp_mem[5] = 32'h5000_0002;  // BR
    exp_mem[6] = 32'hF000_0000;  // HALT
    for (int i = 7; i < 16; i++) exp_mem[i] = 32'hA000_0000 + 32'(i);

    rst_n = 1'b0; req_valid = 1'b0; req_pc = '0; rsp_ready = 1'b1;
    flush = 1'b0; wr_en = 1'b0; wr_addr = '0; wr_data = '0;
`ifdef INSTR_MEM_PARITY_EN
    par_flip = 1'b0;
`endif

    // Reset state
    #1;
    chk("rst_valid", rsp_valid, 0);
    chk("rst_inst",  rsp_inst, 0);
    chk("rst_pc",    rsp_pc, 0);
    chk("rst_fault", rsp_fault, 0);
    tick(); tick();
    rst_n = 1'b1;
    #1;
    chk("ready_after_deassert", req_ready, 0);
    tick();
    chk("ready_one_cycle_later", req_ready, 1);

    // Program load, all 16 words
    for (int i = 0; i < 16; i++) begin
      wr_en = 1'b1; wr_addr = 32'(i); wr_data = exp_mem[i];
      tick();
    end
    wr_en = 1'b0;

    // Back-to-back fetch of PC 0..6
    for (int i = 0; i < 7; i++) begin
      req_valid = 1'b1; req_pc = 32'(i);
      #1;
      chk("b2b_ready", req_ready, 1);
      tick();
      chk("b2b_valid", rsp_valid, 1);
      chk("b2b_pc",    rsp_pc, 64'(i));
      chk("b2b_inst",  rsp_inst, exp_mem[i]);
      chk("b2b_fault", rsp_fault, 0);
    end
    req_valid = 1'b0;
    tick();
    chk("b2b_drain", rsp_valid, 0);

    // Stall: PC 2 held for 3 cycles while PC 3 waits
    req_valid = 1'b1; req_pc = 32'd2;
    tick();
    chk("stall_first_pc", rsp_pc, 2);
    rsp_ready = 1'b0; req_pc = 32'd3;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("stall_ready_low", req_ready, 0);
      tick();
      chk("stall_valid", rsp_valid, 1);
      chk("stall_pc",    rsp_pc, 2);
      chk("stall_inst",  rsp_inst, exp_mem[2]);
    end
    rsp_ready = 1'b1;
    #1;
    chk("stall_release_ready", req_ready, 1);
    tick();
    chk("stall_next_pc",   rsp_pc, 3);
    chk("stall_next_inst", rsp_inst, exp_mem[3]);
    req_valid = 1'b0;
    tick();

    // Out-of-range fetch
    req_valid = 1'b1; req_pc = 32'd16;
    tick();
    chk("oor_valid", rsp_valid, 1);
    chk("oor_pc",    rsp_pc, 16);
    chk("oor_fault", rsp_fault, 1);
    chk("oor_inst",  rsp_inst, 0);
    req_valid = 1'b0;

    // Out-of-range write must not touch any word (20 would alias to 4)
    wr_en = 1'b1; wr_addr = 32'd20; wr_data = 32'h1234_5678;
    tick();
    wr_en = 1'b0;
    for (int i = 0; i < 16; i++) begin
      req_valid = 1'b1; req_pc = 32'(i);
      tick();
      chk("readback_pc",    rsp_pc, 64'(i));
      chk("readback_inst",  rsp_inst, exp_mem[i]);
      chk("readback_fault", rsp_fault, 0);
    end
    req_valid = 1'b0;
    tick();

    // Flush with redirect: stalled PC 4 replaced by PC 2
    rsp_ready = 1'b0; req_valid = 1'b1; req_pc = 32'd4;
    tick();
    req_valid = 1'b0;
    tick();
    chk("flush_held_pc", rsp_pc, 4);
    flush = 1'b1; req_valid = 1'b1; req_pc = 32'd2;
    #1;
    chk("flush_forces_ready", req_ready, 1);
    tick();
    flush = 1'b0; req_valid = 1'b0;
    chk("flush_valid", rsp_valid, 1);
    chk("flush_pc",    rsp_pc, 2);
    chk("flush_inst",  rsp_inst, exp_mem[2]);
    rsp_ready = 1'b1;
    tick();
    chk("flush_drain", rsp_valid, 0);

    // Flush without a request empties the output register
    rsp_ready = 1'b0; req_valid = 1'b1; req_pc = 32'd4;
    tick();
    req_valid = 1'b0; flush = 1'b1;
    tick();
    flush = 1'b0;
    chk("flush_empty", rsp_valid, 0);
    rsp_ready = 1'b1;

    // Read-first collision on address 5
    wr_en = 1'b1; wr_addr = 32'd5; wr_data = 32'hDEAD_BEEF;
    req_valid = 1'b1; req_pc = 32'd5;
    tick();
    wr_en = 1'b0;
    chk("collide_old", rsp_inst, exp_mem[5]);
    tick();
    chk("collide_new", rsp_inst, 32'hDEAD_BEEF);
    exp_mem[5] = 32'hDEAD_BEEF;

    // Asynchronous reset while FULL
    req_pc = 32'd1;
    tick();
    chk("prereset_valid", rsp_valid, 1);
    req_valid = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_valid", rsp_valid, 0);
    chk("async_inst",  rsp_inst, 0);
    chk("async_pc",    rsp_pc, 0);
    chk("async_fault", rsp_fault, 0);
    rst_n = 1'b1;
    tick();
    chk("post_reset_ready", req_ready, 1);

`ifdef INSTR_MEM_PARITY_EN
    // Corrupted parity on write is reported on read, data still returned
    wr_en = 1'b1; wr_addr = 32'd3; wr_data = 32'h0F0F_0001; par_flip = 1'b1;
    tick();
    wr_en = 1'b0; par_flip = 1'b0;
    req_valid = 1'b1; req_pc = 32'd3;
    tick();
    req_valid = 1'b0;
    chk("parity_fault", rsp_fault, 1);
    chk("parity_inst",  rsp_inst, 32'h0F0F_0001);
    tick();
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
